fifo_nbxnw_flags: RTL and testbench
===================================

Name: fifo_nbxnw_flags

Overview:
- Parametrised synchronous single-clock FIFO for narrow control and data streams in the C2C datapath.
- Successor to the fixed-width, fixed-depth register FIFO: width and depth are free parameters.
- Adds fill level, programmable almost-full/almost-empty flags, sticky overflow/underflow errors, synchronous flush, and an optional registered-output mode.
- Storage is a register array (no BRAM inference), sized for shallow depths of 2 to 64 words.

Parameters:
- DATA_W, 5: data width in bits, 1..64.
- ADDR_W, 3: depth = 2**ADDR_W words, ADDR_W in 1..6.
- AFULL_TH, 6: AFULL asserts when LEVEL >= AFULL_TH; range 1..2**ADDR_W.
- AEMPTY_TH, 1: AEMPTY asserts when LEVEL <= AEMPTY_TH; range 0..2**ADDR_W-1.
- OUT_REG, 0: 0 = head word driven combinationally on RDATA (show-ahead); 1 = RDATA registered, loaded on accepted read, qualified by RVALID.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- FLUSH  in  1  synchronous empty request
- WREN  in  1  write request
- WDATA  in  DATA_W  write data
- FULL  out  1  no free entry
- AFULL  out  1  almost full
- RDEN  in  1  read request
- RDATA  out  DATA_W  read data
- RVALID  out  1  OUT_REG=1: RDATA loaded this cycle; OUT_REG=0: equals ~EMPTY
- EMPTY  out  1  no stored entry
- AEMPTY  out  1  almost empty
- LEVEL  out  ADDR_W+1  stored word count, 0..2**ADDR_W
- OVF  out  1  sticky: write attempted while full and not accepted
- UDF  out  1  sticky: read attempted while empty
- ERR_CLR  in  1  clears OVF/UDF

Behaviour:
Reset (RST_N=0, async)
- wptr, rptr, LEVEL, OVF, UDF, RVALID and registered RDATA reset to 0.
- All storage words reset to 0.
- Resulting outputs: EMPTY=1, FULL=0, AEMPTY=1, AFULL=(AFULL_TH==0 ? 1 : 0).
- Reset asserted mid-burst discards all contents immediately.

Pointers and flags
- wptr and rptr are ADDR_W+1 bits and wrap modulo 2**(ADDR_W+1); the low ADDR_W bits index storage.
- EMPTY = (wptr == rptr).
- FULL = (MSBs differ, low bits equal).
- LEVEL = wptr - rptr, computed modulo 2**(ADDR_W+1).
- FULL, EMPTY, AFULL and AEMPTY are combinational from registers only (no input-to-output paths) and reflect state after each edge.

Write acceptance: wacc = WREN & (~FULL | racc).
- A write while full is accepted only together with an accepted read.
- On wacc: mem[wptr] <= WDATA, wptr += 1.
- WREN while FULL without racc: write dropped, pointers unchanged, OVF <= 1.

Read acceptance: racc = RDEN & ~EMPTY.
- On racc: rptr += 1.
- RDEN while EMPTY: read ignored, UDF <= 1. A same-cycle write is still accepted; it is not bypassed to the output.

Simultaneous read and write
- Both accepted: LEVEL unchanged, FULL/EMPTY unchanged.
- When full, the write targets the slot being read this cycle. In OUT_REG=0 the old word is already presented on RDATA; in OUT_REG=1 it is captured at this edge.

OUT_REG=0
- RDATA = mem[rptr[ADDR_W-1:0]], combinational.
- RDATA is don't-care while EMPTY.
- Zero-latency show-ahead: RDEN consumes the displayed word.

OUT_REG=1
- On racc: RDATA <= mem[rptr], RVALID <= 1. Otherwise RVALID <= 0 and RDATA holds.
- Read latency is 1 cycle.

FLUSH (synchronous, highest priority)
- Sets wptr = rptr = 0 and RVALID = 0.
- WREN and RDEN in the same cycle are ignored and do not set OVF/UDF.
- Storage and RDATA register are not cleared.
- OVF/UDF are unaffected.

ERR_CLR
- Clears OVF/UDF at the next edge.
- A new error event in the same cycle wins: the flag is set.

Illegal parameters: AFULL_TH > 2**ADDR_W or ADDR_W outside 1..6 are rejected by an elaboration-time check.

Test Plan (defaults unless stated):
- Reset, then write 0x01..0x08 on 8 consecutive cycles -> LEVEL 1..8; AEMPTY drops once LEVEL=2; AFULL at LEVEL=6; FULL at LEVEL=8; 9th WREN with 0x1F -> OVF=1, LEVEL=8, contents intact.
- From full, RDEN for 8 cycles (OUT_REG=0) -> RDATA 0x01..0x08 in order; EMPTY after the last read; a further RDEN -> UDF=1, LEVEL=0.
- OUT_REG=1: write 0x0A, 0x0B, then RDEN 2 cycles -> RVALID high on the 2 cycles after each RDEN with RDATA 0x0A then 0x0B; RVALID=0 otherwise.
- Full FIFO, WREN+RDEN with WDATA=0x15 -> OVF stays 0; RDATA was the oldest word; LEVEL=8; 0x15 emerges 8 reads later. Pointer wrap is exercised by 20 write/read rounds, checking LEVEL after each.
- LEVEL=5 with FLUSH+WREN+RDEN asserted -> next cycle LEVEL=0, EMPTY=1, no OVF/UDF; then write 0x03 -> RDATA 0x03.
- OVF=UDF=1, ERR_CLR together with RDEN while empty -> UDF stays 1, OVF clears. RST_N pulsed low mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_nbxnw_flags.sv
// Parametrised single-clock register FIFO with fill level, programmable almost flags,
// sticky overflow/underflow errors, synchronous flush and optional registered read data.
module fifo_nbxnw_flags #(
  parameter int DATA_W    = 5,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1,
  parameter int OUT_REG   = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              WREN,
  input  logic [DATA_W-1:0] WDATA,
  output logic              FULL,
  output logic              AFULL,
  input  logic              RDEN,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic              EMPTY,
  output logic              AEMPTY,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVF,
  output logic              UDF,
  input  logic              ERR_CLR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);

  if (ADDR_W < 1 || ADDR_W > 6 || AFULL_TH > DEPTH) begin : g_bad_param
    $error("fifo_nbxnw_flags: ADDR_W must be 1..6 and AFULL_TH <= 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              racc;
  logic              wacc;
  logic              ovf_set;
  logic              udf_set;

  // Flags depend on pointer registers only, never on this cycle's requests
  assign EMPTY  = (wptr == rptr);
  assign FULL   = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                  (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign LEVEL  = wptr - rptr;
  assign AFULL  = (LEVEL >= AFULL_LV);
  assign AEMPTY = (LEVEL <= AEMPTY_LV);

  // A full FIFO still takes a write when the head leaves in the same cycle
  assign racc    = RDEN & ~EMPTY & ~FLUSH;
  assign wacc    = WREN & (~FULL | racc) & ~FLUSH;
  assign ovf_set = WREN & ~FLUSH & ~wacc;
  assign udf_set = RDEN & ~FLUSH & EMPTY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else if (FLUSH) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wacc) wptr <= wptr + 1'b1;
      if (racc) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wacc) begin
      mem[wptr[ADDR_W-1:0]] <= WDATA;
    end
  end

  // New error events take precedence over a same-cycle clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (ovf_set)      OVF <= 1'b1;
      else if (ERR_CLR) OVF <= 1'b0;
      if (udf_set)      UDF <= 1'b1;
      else if (ERR_CLR) UDF <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] rdata_p1;
    logic              rvld_p1;

    // Stage p1: head word captured on an accepted read
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        rdata_p1 <= '0;
        rvld_p1  <= 1'b0;
      end else begin
        rvld_p1 <= racc;
        if (racc) rdata_p1 <= mem[rptr[ADDR_W-1:0]];
      end
    end

    assign RDATA  = rdata_p1;
    assign RVALID = rvld_p1;
  end else begin : g_out_comb
    assign RDATA  = mem[rptr[ADDR_W-1:0]];
    assign RVALID = ~EMPTY;
  end

endmodule

// File: tb/tb_fifo_nbxnw_flags.sv
// Bench for fifo_nbxnw_flags: show-ahead and registered-output instances share stimulus,
// checked against a queue-based reference model, a vector table and corner sequences.
module tb_fifo_nbxnw_flags;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, wren, rden, errclr;
  logic [4:0] wdata;

  logic       full0, afull0, rvalid0, empty0, aempty0, ovf0, udf0;
  logic [4:0] rdata0;
  logic [3:0] level0;
  logic       full1, afull1, rvalid1, empty1, aempty1, ovf1, udf1;
  logic [4:0] rdata1;
  logic [3:0] level1;

  always #5 clk = ~clk;

  fifo_nbxnw_flags #(.DATA_W(5), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .OUT_REG(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .WREN(wren), .WDATA(wdata),
    .FULL(full0), .AFULL(afull0), .RDEN(rden), .RDATA(rdata0), .RVALID(rvalid0),
    .EMPTY(empty0), .AEMPTY(aempty0), .LEVEL(level0), .OVF(ovf0), .UDF(udf0),
    .ERR_CLR(errclr));

  fifo_nbxnw_flags #(.DATA_W(5), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .OUT_REG(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .WREN(wren), .WDATA(wdata),
    .FULL(full1), .AFULL(afull1), .RDEN(rden), .RDATA(rdata1), .RVALID(rvalid1),
    .EMPTY(empty1), .AEMPTY(aempty1), .LEVEL(level1), .OVF(ovf1), .UDF(udf1),
    .ERR_CLR(errclr));

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a queue of stored words plus error and registered-output state
  logic [4:0] q[$];
  bit         m_ovf, m_udf, m_rv;
  logic [4:0] m_rd;
  logic [4:0] pre_rd;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_step(input bit f, w, input logic [4:0] d, input bit r, e);
    bit racc, wacc, oe, ue;
    oe = 0; ue = 0;
    if (f) begin
      q.delete();
      m_rv = 0;
    end else begin
      racc = r && q.size() != 0;
      wacc = w && (q.size() < DEPTH || racc);
      oe   = w && !wacc;
      ue   = r && q.size() == 0;
      if (racc) begin
        m_rd = q.pop_front();
        m_rv = 1;
      end else begin
        m_rv = 0;
      end
      if (wacc) q.push_back(d);
    end
    m_ovf = oe ? 1'b1 : (e ? 1'b0 : m_ovf);
    m_udf = ue ? 1'b1 : (e ? 1'b0 : m_udf);
  endtask

  task automatic model_check();
    int lv;
    lv = q.size();
    chk("level",   level0,  lv);
    chk("level1",  level1,  lv);
    chk("empty",   empty0,  lv == 0);
    chk("full",    full0,   lv == DEPTH);
    chk("afull",   afull0,  lv >= 6);
    chk("aempty",  aempty0, lv <= 1);
    chk("ovf",     ovf0,    m_ovf);
    chk("udf",     udf0,    m_udf);
    chk("rvalid0", rvalid0, lv != 0);
    if (lv != 0) chk("rdata0", rdata0, q[0]);
    chk("rvalid1", rvalid1, m_rv);
    chk("rdata1",  rdata1,  m_rd);
  endtask

  // Drive one cycle of requests, capture the pre-edge show-ahead word, then check post-edge
  task automatic step(input bit f, w, input logic [4:0] d, input bit r, e);
    flush = f; wren = w; wdata = d; rden = r; errclr = e;
    #1 pre_rd = rdata0;
    @(posedge clk);
    #1;
    model_step(f, w, d, r, e);
    model_check();
    flush = 0; wren = 0; rden = 0; errclr = 0;
  endtask

  typedef struct {
    bit f, w; logic [4:0] d; bit r, e;
    bit chk_rd; logic [4:0] exp_rd;
    int lvl; bit full, empty, afull, aempty, ovf, udf;
  } vec_t;

  function automatic vec_t mkv(bit w, logic [4:0] d, bit r, bit chk_rd, logic [4:0] exp_rd,
                               int lvl, bit full, bit empty, bit afull, bit aempty,
                               bit ovf, bit udf);
    vec_t v;
    v.f = 0; v.w = w; v.d = d; v.r = r; v.e = 0;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.lvl = lvl; v.full = full; v.empty = empty;
    v.afull = afull; v.aempty = aempty; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  vec_t vt[18];

  initial begin
    //            w  d      r  chk exp    lvl full emp afl aem ovf udf
    vt[0]  = mkv(1, 5'h01, 0, 0, 5'h00, 1, 0, 0, 0, 1, 0, 0);
    vt[1]  = mkv(1, 5'h02, 0, 0, 5'h00, 2, 0, 0, 0, 0, 0, 0);
    vt[2]  = mkv(1, 5'h03, 0, 0, 5'h00, 3, 0, 0, 0, 0, 0, 0);
    vt[3]  = mkv(1, 5'h04, 0, 0, 5'h00, 4, 0, 0, 0, 0, 0, 0);
    vt[4]  = mkv(1, 5'h05, 0, 0, 5'h00, 5, 0, 0, 0, 0, 0, 0);
    vt[5]  = mkv(1, 5'h06, 0, 0, 5'h00, 6, 0, 0, 1, 0, 0, 0);
    vt[6]  = mkv(1, 5'h07, 0, 0, 5'h00, 7, 0, 0, 1, 0, 0, 0);
    vt[7]  = mkv(1, 5'h08, 0, 0, 5'h00, 8, 1, 0, 1, 0, 0, 0);
    vt[8]  = mkv(1, 5'h1F, 0, 0, 5'h00, 8, 1, 0, 1, 0, 1, 0);
    vt[9]  = mkv(0, 5'h00, 1, 1, 5'h01, 7, 0, 0, 1, 0, 1, 0);
    vt[10] = mkv(0, 5'h00, 1, 1, 5'h02, 6, 0, 0, 1, 0, 1, 0);
    vt[11] = mkv(0, 5'h00, 1, 1, 5'h03, 5, 0, 0, 0, 0, 1, 0);
    vt[12] = mkv(0, 5'h00, 1, 1, 5'h04, 4, 0, 0, 0, 0, 1, 0);
    vt[13] = mkv(0, 5'h00, 1, 1, 5'h05, 3, 0, 0, 0, 0, 1, 0);
    vt[14] = mkv(0, 5'h00, 1, 1, 5'h06, 2, 0, 0, 0, 0, 1, 0);
    vt[15] = mkv(0, 5'h00, 1, 1, 5'h07, 1, 0, 0, 0, 1, 1, 0);
    vt[16] = mkv(0, 5'h00, 1, 1, 5'h08, 0, 0, 1, 0, 1, 1, 0);
    vt[17] = mkv(0, 5'h00, 1, 0, 5'h00, 0, 0, 1, 0, 1, 1, 1);

    rst_n = 0; flush = 0; wren = 0; rden = 0; errclr = 0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty0, 1);  chk("rst_full", full0, 0);
    chk("rst_aempty", aempty0, 1); chk("rst_afull", afull0, 0);
    chk("rst_level", level0, 0);  chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);      chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata1", rdata1, 0);
    rst_n = 1;

    // Fill to overflow, drain to underflow
    for (int i = 0; i < 18; i++) begin
      step(vt[i].f, vt[i].w, vt[i].d, vt[i].r, vt[i].e);
      if (vt[i].chk_rd) chk($sformatf("tbl%0d_rd", i), pre_rd, vt[i].exp_rd);
      chk($sformatf("tbl%0d_lvl", i), level0, vt[i].lvl);
      chk($sformatf("tbl%0d_full", i), full0, vt[i].full);
      chk($sformatf("tbl%0d_empty", i), empty0, vt[i].empty);
      chk($sformatf("tbl%0d_afull", i), afull0, vt[i].afull);
      chk($sformatf("tbl%0d_aempty", i), aempty0, vt[i].aempty);
      chk($sformatf("tbl%0d_ovf", i), ovf0, vt[i].ovf);
      chk($sformatf("tbl%0d_udf", i), udf0, vt[i].udf);
    end
    step(0, 0, 0, 0, 1);
    chk("clr_ovf", ovf0, 0); chk("clr_udf", udf0, 0);

    // Registered output: one-cycle latency, RVALID only after accepted reads
    step(0, 1, 5'h0A, 0, 0);
    chk("oreg_idle_v", rvalid1, 0);
    step(0, 1, 5'h0B, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("oreg_v0", rvalid1, 1); chk("oreg_d0", rdata1, 5'h0A);
    step(0, 0, 0, 1, 0);
    chk("oreg_v1", rvalid1, 1); chk("oreg_d1", rdata1, 5'h0B);
    step(0, 0, 0, 0, 0);
    chk("oreg_v2", rvalid1, 0); chk("oreg_hold", rdata1, 5'h0B);

    // Simultaneous read and write while full
    for (int i = 0; i < 8; i++) step(0, 1, 5'(5'h10 + i), 0, 0);
    step(0, 1, 5'h15, 1, 0);
    chk("rw_full_rd", pre_rd, 5'h10); chk("rw_full_ovf", ovf0, 0);
    chk("rw_full_lvl", level0, 8);    chk("rw_full_d1", rdata1, 5'h10);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rw_full_last", pre_rd, 5'h15); chk("rw_full_empty", empty0, 1);

    // Pointer wrap rounds
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 5'($urandom), 0, 0);
      step(0, 0, 0, 1, 0);
      chk($sformatf("wrap%0d_lvl", i), level0, 0);
    end

    // Flush beats same-cycle requests
    for (int i = 0; i < 5; i++) step(0, 1, 5'(i + 1), 0, 0);
    chk("pre_flush_lvl", level0, 5);
    step(1, 1, 5'h1E, 1, 0);
    chk("flush_lvl", level0, 0); chk("flush_empty", empty0, 1);
    chk("flush_ovf", ovf0, 0);   chk("flush_udf", udf0, 0);
    chk("flush_rv1", rvalid1, 0);
    step(0, 1, 5'h03, 0, 0);
    chk("post_flush_rd", rdata0, 5'h03);

    // Error clear loses to a same-cycle underflow
    for (int i = 0; i < 8; i++) step(0, 1, 5'(i), 0, 0);
    step(0, 1, 5'h1F, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
    chk("both_ovf", ovf0, 1); chk("both_udf", udf0, 1);
    step(0, 0, 0, 1, 1);
    chk("clr_race_udf", udf0, 1); chk("clr_race_ovf", ovf0, 0);
    step(0, 0, 0, 0, 1);

    // Randomized traffic with shifting read/write bias
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      pw = (i / 100) % 2 == 0 ? 70 : 35;
      pr = (i / 100) % 2 == 0 ? 35 : 70;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < pw, 5'($urandom),
           $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 5);
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) step(0, 1, 5'(i + 7), i > 1, 0);
    wren = 1; rden = 1; wdata = 5'h11;
    #2 rst_n = 0;
    #1;
    chk("arst_level", level0, 0);  chk("arst_empty", empty0, 1);
    chk("arst_full", full0, 0);    chk("arst_aempty", aempty0, 1);
    chk("arst_afull", afull0, 0);  chk("arst_ovf", ovf0, 0);
    chk("arst_udf", udf0, 0);      chk("arst_rvalid1", rvalid1, 0);
    chk("arst_rdata1", rdata1, 0);
    wren = 0; rden = 0;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    step(0, 1, 5'h09, 0, 0);
    chk("after_rst_rd", rdata0, 5'h09);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
